vend_ctrl: RTL and testbench
============================

VEND_CTRL -- requirements
Module: vend_ctrl

Interface
REQ-001 Parameters SHALL be: PRICE1_H, default 5, price of item 1 in half-yuan units (2.5 yuan). PRICE2_H, default 10, price of item 2 in half-yuan units. MAX_AMT_H, default 39, credit ceiling in half-yuan units (19.5 yuan). MAX_NUM, default 5, per-item quantity limit. DISP_CYCLES, default 8, DISPENSE dwell. TIMEOUT_CYCLES, default 1024, idle timeout.
REQ-002 Ports SHALL be, as name, direction, width, meaning:
- clk  in  1  single system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- power_on  in  1  level; machine powered.
- start  in  1  one-cycle pulse; enter service.
- coin_pulse  in  1  one-cycle pulse; coin inserted.
- coin_sel  in  2  coin value: 00=0.5, 01=1, 10=5, 11=10 yuan.
- sel1, sel2  in  1 each  one-cycle pulses; add one unit of item 1 or item 2.
- buy  in  1  one-cycle pulse; purchase request.
- cancel  in  1  one-cycle pulse; abort and refund.
- open, hold_ind  out  1 each  powered / in service.
- coin_val  out  5  credit integer yuan.
- coin_float  out  1  credit has a 0.5 yuan part.
- charge_val  out  5  change integer yuan.
- charge_float  out  1  change has a 0.5 yuan part.
- num1, num2  out  5 each  selected quantities.
- coin_in, op_start, cancel_flag  out  1 each  one-cycle strobes.
- reject, dispense  out  1 each  coin-rejected strobe / dispense active.
- busy  out  1  DISPENSE or REFUND active.

Function
REQ-003 FSM states SHALL be OFF, WELCOME, HOLD, DISPENSE and REFUND.
- OFF goes to WELCOME when power_on=1.
- WELCOME goes to HOLD on start.
- Any state goes to OFF, with all registers cleared, one cycle after power_on=0.
REQ-004 Credit SHALL be held in a 6-bit half-unit register amt_h, with coin_val=amt_h>>1 and coin_float=amt_h[0], all registered.
REQ-005 In HOLD, a coin_pulse SHALL add 1/2/10/20 half-units and pulse coin_in in the next cycle; if the sum would exceed MAX_AMT_H, amt_h SHALL stay unchanged and reject SHALL pulse instead.
REQ-006 In HOLD, sel1/sel2 SHALL increment num1/num2 and saturate at MAX_NUM with no wrap.
REQ-007 In HOLD, buy SHALL compute cost=num1*PRICE1_H+num2*PRICE2_H at 7-bit width:
- cost>amt_h or cost=0: pulse op_start, make no state change.
- otherwise: set charge=amt_h-cost, clear amt_h and num1/num2, pulse op_start, enter DISPENSE.
REQ-008 DISPENSE SHALL hold dispense=1 for exactly DISP_CYCLES cycles, then return to HOLD; charge_val/charge_float SHALL stay valid until the next buy or cancel.
REQ-009 In HOLD, cancel SHALL set charge=amt_h, clear amt_h and num1/num2, pulse cancel_flag, and enter REFUND for 1 cycle before returning to HOLD.
REQ-010 Simultaneous inputs SHALL resolve with priority cancel > buy > coin_pulse > sel1 > sel2; each lower-priority pulse in that cycle SHALL be dropped.
REQ-011 Inputs other than power_on SHALL be ignored outside HOLD, and a coin_pulse arriving during busy SHALL be rejected.
REQ-012 The outputs open=(state!=OFF) and hold_ind=(state in HOLD, DISPENSE, REFUND) SHALL be registered.

Reset
REQ-013 reset=0 SHALL immediately force state=OFF and drive every output and register to 0.
REQ-014 A reset asserted mid-DISPENSE or mid-REFUND SHALL abort it with no refund retained.

Configuration
REQ-015 With VEND_TIMEOUT_EN defined, a counter SHALL count HOLD cycles with no input pulse; on reaching TIMEOUT_CYCLES with amt_h>0 it SHALL perform the REQ-009 cancel, and with amt_h=0 it SHALL return to WELCOME.
REQ-016 Without VEND_TIMEOUT_EN, neither the counter nor its logic SHALL exist, and HOLD SHALL persist indefinitely.

Structure
REQ-017 A shared package vend_pkg SHALL hold the state enum, coin-code constants and the half-unit coin value table.
REQ-018 The cost/change arithmetic SHALL be a sub-module vend_price (combinational, num1/num2/amt_h in; cost, sufficient and change out).

Verification
REQ-019 Power and start: power_on=1, then start -> open=1 after 1 cycle; hold_ind=1 after start; coin_val=0, coin_float=0.
REQ-020 Coins 10+5+1+0.5 -> coin_val=16, coin_float=1; a following 5-yuan coin -> reject pulse, credit unchanged.
REQ-021 Credit 10.0 (amt_h=20), sel1 x2, sel2 x1, buy -> cost 20; dispense high 8 cycles; charge_val=0, charge_float=0; num1=num2=0.
REQ-022 Credit 2.0, sel2, buy -> op_start pulses, state stays HOLD, credit 2.0 retained; then cancel -> charge_val=2, cancel_flag pulse, coin_val=0.
REQ-023 Boundary cases:
- sel1 x7 -> num1=5.
- cancel and buy in the same cycle -> refund path only.
- reset low during DISPENSE -> all outputs 0 immediately.
REQ-024 With VEND_TIMEOUT_EN, TIMEOUT_CYCLES=16: credit 1.5 then idle 16 cycles -> auto-refund, charge_val=1, charge_float=1.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared types and constants for the vending controller.
// Money is kept in half-yuan units throughout, so 0.5 yuan is the LSB.
package vend_pkg;

  typedef enum logic [2:0] {
    ST_OFF,
    ST_WELCOME,
    ST_HOLD,
    ST_DISPENSE,
    ST_REFUND
  } state_t;

  localparam logic [1:0] COIN_0P5 = 2'b00;
  localparam logic [1:0] COIN_1   = 2'b01;
  localparam logic [1:0] COIN_5   = 2'b10;
  localparam logic [1:0] COIN_10  = 2'b11;

  // Half-unit value of each coin code, indexed by coin_sel.
  localparam logic [5:0] COIN_HALF [4] = '{6'd1, 6'd2, 6'd10, 6'd20};

  function automatic logic [5:0] coin_half_units(input logic [1:0] code);
    return COIN_HALF[code];
  endfunction

endpackage

// File: rtl/vend_price.sv
// Combinational cost/change calculator for the current selection.
// A zero-cost basket is never "sufficient" so an empty buy does nothing.
module vend_price
  import vend_pkg::*;
#(
  parameter int PRICE1_H = 5,
  parameter int PRICE2_H = 10
) (
  input  logic [4:0] num1,
  input  logic [4:0] num2,
  input  logic [5:0] amt_h,
  output logic [6:0] cost,
  output logic       sufficient,
  output logic [5:0] change
);

  always_comb begin
    cost       = 7'(num1 * PRICE1_H + num2 * PRICE2_H);
    sufficient = (cost != 7'd0) && (cost <= {1'b0, amt_h});
    change     = amt_h - cost[5:0];
  end

endmodule

// File: rtl/vend_ctrl.sv
// Vending machine controller: coin credit, item selection, dispense and refund.
// Optional idle timeout (auto-refund / back to WELCOME) enabled by VEND_TIMEOUT_EN.
module vend_ctrl
  import vend_pkg::*;
#(
  parameter int PRICE1_H       = 5,
  parameter int PRICE2_H       = 10,
  parameter int MAX_AMT_H      = 39,
  parameter int MAX_NUM        = 5,
  parameter int DISP_CYCLES    = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       power_on,
  input  logic       start,
  input  logic       coin_pulse,
  input  logic [1:0] coin_sel,
  input  logic       sel1,
  input  logic       sel2,
  input  logic       buy,
  input  logic       cancel,
  output logic       open,
  output logic       hold_ind,
  output logic [4:0] coin_val,
  output logic       coin_float,
  output logic [4:0] charge_val,
  output logic       charge_float,
  output logic [4:0] num1,
  output logic [4:0] num2,
  output logic       coin_in,
  output logic       op_start,
  output logic       cancel_flag,
  output logic       reject,
  output logic       dispense,
  output logic       busy
);

  localparam int DW = $clog2(DISP_CYCLES + 1);

  state_t        state, state_next;
  logic [5:0]    amt_h, amt_h_next, charge_h, charge_h_next;
  logic [4:0]    num1_next, num2_next;
  logic          coin_in_next, op_start_next, cancel_flag_next, reject_next;
  logic [DW-1:0] disp_cnt, disp_cnt_next;
  logic [6:0]    cost, coin_sum;
  logic [5:0]    change;
  logic          sufficient, coin_ok;
  logic          in_hold, do_cancel, do_buy, do_coin, do_sel1, do_sel2, do_idle_exit;

  vend_price #(.PRICE1_H(PRICE1_H), .PRICE2_H(PRICE2_H)) u_price (
    .num1      (num1),
    .num2      (num2),
    .amt_h     (amt_h),
    .cost      (cost),
    .sufficient(sufficient),
    .change    (change)
  );

  assign in_hold = (state == ST_HOLD);

`ifdef VEND_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] idle_cnt;
  logic          any_pulse, timeout_hit;

  assign any_pulse   = coin_pulse | sel1 | sel2 | buy | cancel;
  assign timeout_hit = in_hold && !any_pulse && (idle_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      idle_cnt <= '0;
    else if (!power_on || !in_hold || any_pulse || timeout_hit)
      idle_cnt <= '0;
    else
      idle_cnt <= idle_cnt + 1'b1;
  end

  assign do_cancel    = in_hold && (cancel || (timeout_hit && amt_h != 6'd0));
  assign do_idle_exit = timeout_hit && (amt_h == 6'd0);
`else
  assign do_cancel    = in_hold && cancel;
  assign do_idle_exit = 1'b0;
`endif

  // Strict priority: each lower-priority pulse is dropped when a higher one is present.
  assign do_buy  = in_hold && !do_cancel && buy;
  assign do_coin = in_hold && !do_cancel && !buy && coin_pulse;
  assign do_sel1 = in_hold && !do_cancel && !buy && !coin_pulse && sel1;
  assign do_sel2 = in_hold && !do_cancel && !buy && !coin_pulse && !sel1 && sel2;

  assign coin_sum = {1'b0, amt_h} + {1'b0, coin_half_units(coin_sel)};
  assign coin_ok  = (coin_sum <= 7'(MAX_AMT_H));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_OFF;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (!power_on) begin
      state_next = ST_OFF;
    end else begin
      case (state)
        ST_OFF:      state_next = ST_WELCOME;
        ST_WELCOME:  if (start) state_next = ST_HOLD;
        ST_HOLD: begin
          if (do_cancel)                state_next = ST_REFUND;
          else if (do_buy && sufficient) state_next = ST_DISPENSE;
          else if (do_idle_exit)        state_next = ST_WELCOME;
        end
        ST_DISPENSE: if (disp_cnt == DW'(DISP_CYCLES - 1)) state_next = ST_HOLD;
        ST_REFUND:   state_next = ST_HOLD;
        default:     state_next = ST_OFF;
      endcase
    end
  end

  always_comb begin
    amt_h_next       = amt_h;
    charge_h_next    = charge_h;
    num1_next        = num1;
    num2_next        = num2;
    coin_in_next     = 1'b0;
    op_start_next    = 1'b0;
    cancel_flag_next = 1'b0;
    reject_next      = 1'b0;
    disp_cnt_next    = (state == ST_DISPENSE) ? disp_cnt + 1'b1 : '0;

    if (do_cancel) begin
      charge_h_next    = amt_h;
      amt_h_next       = 6'd0;
      num1_next        = 5'd0;
      num2_next        = 5'd0;
      cancel_flag_next = 1'b1;
    end else if (do_buy) begin
      op_start_next = 1'b1;
      if (sufficient) begin
        charge_h_next = change;
        amt_h_next    = 6'd0;
        num1_next     = 5'd0;
        num2_next     = 5'd0;
      end
    end else if (do_coin) begin
      if (coin_ok) begin
        amt_h_next   = coin_sum[5:0];
        coin_in_next = 1'b1;
      end else begin
        reject_next = 1'b1;
      end
    end else if (do_sel1) begin
      if (num1 < 5'(MAX_NUM)) num1_next = num1 + 5'd1;
    end else if (do_sel2) begin
      if (num2 < 5'(MAX_NUM)) num2_next = num2 + 5'd1;
    end else if (do_idle_exit) begin
      num1_next = 5'd0;
      num2_next = 5'd0;
    end

    if ((state == ST_DISPENSE || state == ST_REFUND) && coin_pulse) reject_next = 1'b1;

    if (!power_on) begin
      amt_h_next       = 6'd0;
      charge_h_next    = 6'd0;
      num1_next        = 5'd0;
      num2_next        = 5'd0;
      coin_in_next     = 1'b0;
      op_start_next    = 1'b0;
      cancel_flag_next = 1'b0;
      reject_next      = 1'b0;
      disp_cnt_next    = '0;
    end
  end

  // Status flags are registered from state_next so they line up with the state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      amt_h       <= 6'd0;
      charge_h    <= 6'd0;
      num1        <= 5'd0;
      num2        <= 5'd0;
      coin_in     <= 1'b0;
      op_start    <= 1'b0;
      cancel_flag <= 1'b0;
      reject      <= 1'b0;
      disp_cnt    <= '0;
      open        <= 1'b0;
      hold_ind    <= 1'b0;
      dispense    <= 1'b0;
      busy        <= 1'b0;
    end else begin
      amt_h       <= amt_h_next;
      charge_h    <= charge_h_next;
      num1        <= num1_next;
      num2        <= num2_next;
      coin_in     <= coin_in_next;
      op_start    <= op_start_next;
      cancel_flag <= cancel_flag_next;
      reject      <= reject_next;
      disp_cnt    <= disp_cnt_next;
      open        <= (state_next != ST_OFF);
      hold_ind    <= (state_next == ST_HOLD) || (state_next == ST_DISPENSE) ||
                     (state_next == ST_REFUND);
      dispense    <= (state_next == ST_DISPENSE);
      busy        <= (state_next == ST_DISPENSE) || (state_next == ST_REFUND);
    end
  end

  assign coin_val     = amt_h[5:1];
  assign coin_float   = amt_h[0];
  assign charge_val   = charge_h[5:1];
  assign charge_float = charge_h[0];

endmodule

// File: tb/tb_vend_ctrl.sv
// Self-checking bench for vend_ctrl: directed scenarios plus randomized traffic
// compared each cycle against a money-in-half-yuan behavioural model.
module tb_vend_ctrl;

  localparam int P1 = 5, P2 = 10, MAXC = 39, MAXN = 5, DISP = 8;
  localparam int M_OFF = 0, M_WELCOME = 1, M_HOLD = 2, M_DISP = 3, M_REFUND = 4;

  logic       clk = 1'b0;
  logic       reset, power_on, start, coin_pulse, sel1, sel2, buy, cancel;
  logic [1:0] coin_sel;
  logic       open, hold_ind, coin_float, charge_float;
  logic [4:0] coin_val, charge_val, num1, num2;
  logic       coin_in, op_start, cancel_flag, reject, dispense, busy;

  int total = 0, bad = 0, cyc = 0;

  // Behavioural model state (money in half-yuan).
  int m_mode, m_credit, m_charge, m_n1, m_n2, m_left;
  int e_coin_in, e_op, e_cflag, e_reject;
  int coin_half [4] = '{1, 2, 10, 20};  // 0.5, 1, 5, 10 yuan doubled

  vend_ctrl #(
    .PRICE1_H(P1), .PRICE2_H(P2), .MAX_AMT_H(MAXC), .MAX_NUM(MAXN),
    .DISP_CYCLES(DISP), .TIMEOUT_CYCLES(1024)
  ) dut (
    .clk(clk), .reset(reset), .power_on(power_on), .start(start),
    .coin_pulse(coin_pulse), .coin_sel(coin_sel), .sel1(sel1), .sel2(sel2),
    .buy(buy), .cancel(cancel), .open(open), .hold_ind(hold_ind),
    .coin_val(coin_val), .coin_float(coin_float), .charge_val(charge_val),
    .charge_float(charge_float), .num1(num1), .num2(num2), .coin_in(coin_in),
    .op_start(op_start), .cancel_flag(cancel_flag), .reject(reject),
    .dispense(dispense), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s @cyc %0d: got=%0d expected=%0d", tag, cyc, got, exp);
    end
  endtask

  task automatic model_clear();
    m_mode = M_OFF; m_credit = 0; m_charge = 0; m_n1 = 0; m_n2 = 0; m_left = 0;
    e_coin_in = 0; e_op = 0; e_cflag = 0; e_reject = 0;
  endtask

  task automatic model_step();
    int cost;
    e_coin_in = 0; e_op = 0; e_cflag = 0; e_reject = 0;
    if (!power_on) begin
      model_clear();
      return;
    end
    case (m_mode)
      M_OFF:     m_mode = M_WELCOME;
      M_WELCOME: if (start) m_mode = M_HOLD;
      M_HOLD: begin
        if (cancel) begin
          m_charge = m_credit; m_credit = 0; m_n1 = 0; m_n2 = 0;
          e_cflag = 1; m_mode = M_REFUND;
        end else if (buy) begin
          cost = m_n1 * P1 + m_n2 * P2;
          e_op = 1;
          if (cost > 0 && cost <= m_credit) begin
            m_charge = m_credit - cost; m_credit = 0; m_n1 = 0; m_n2 = 0;
            m_mode = M_DISP; m_left = DISP;
          end
        end else if (coin_pulse) begin
          if (m_credit + coin_half[coin_sel] > MAXC) e_reject = 1;
          else begin m_credit += coin_half[coin_sel]; e_coin_in = 1; end
        end else if (sel1) begin
          if (m_n1 < MAXN) m_n1++;
        end else if (sel2) begin
          if (m_n2 < MAXN) m_n2++;
        end
      end
      M_DISP: begin
        if (coin_pulse) e_reject = 1;
        m_left--;
        if (m_left == 0) m_mode = M_HOLD;
      end
      default: begin
        if (coin_pulse) e_reject = 1;
        m_mode = M_HOLD;
      end
    endcase
  endtask

  task automatic compare_all();
    chk("open", open, m_mode != M_OFF);
    chk("hold_ind", hold_ind, m_mode >= M_HOLD);
    chk("coin_val", coin_val, m_credit / 2);
    chk("coin_float", coin_float, m_credit % 2);
    chk("charge_val", charge_val, m_charge / 2);
    chk("charge_float", charge_float, m_charge % 2);
    chk("num1", num1, m_n1);
    chk("num2", num2, m_n2);
    chk("coin_in", coin_in, e_coin_in);
    chk("op_start", op_start, e_op);
    chk("cancel_flag", cancel_flag, e_cflag);
    chk("reject", reject, e_reject);
    chk("dispense", dispense, m_mode == M_DISP);
    chk("busy", busy, m_mode == M_DISP || m_mode == M_REFUND);
  endtask

  // One clock: edge, model update, compare, then drop the one-cycle pulses.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    cyc++;
    compare_all();
    start = 0; coin_pulse = 0; sel1 = 0; sel2 = 0; buy = 0; cancel = 0;
  endtask

  task automatic put_coin(input logic [1:0] code);
    coin_pulse = 1; coin_sel = code; tick();
  endtask

  task automatic do_sel(input int which, input int times);
    for (int k = 0; k < times; k++) begin
      if (which == 1) sel1 = 1; else sel2 = 1;
      tick();
    end
  endtask

  initial begin
    int cnt;
    reset = 0; power_on = 0; start = 0; coin_pulse = 0; coin_sel = 0;
    sel1 = 0; sel2 = 0; buy = 0; cancel = 0;
    model_clear();
    #12;
    compare_all();
    @(negedge clk) reset = 1;

    // Power up and enter service.
    power_on = 1; tick();
    chk("pwr_open", open, 1); chk("pwr_hold", hold_ind, 0);
    start = 1; tick();
    chk("start_hold", hold_ind, 1); chk("start_coin", coin_val, 0); chk("start_float", coin_float, 0);

    // 10 + 5 + 1 + 0.5 yuan, then a 5-yuan coin exceeds the ceiling.
    put_coin(2'b11); put_coin(2'b10); put_coin(2'b01); put_coin(2'b00);
    chk("c16_val", coin_val, 16); chk("c16_float", coin_float, 1);
    put_coin(2'b10);
    chk("ovf_reject", reject, 1); chk("ovf_coin_in", coin_in, 0); chk("ovf_val", coin_val, 16);
    cancel = 1; tick(); tick();
    chk("ref_charge", charge_val, 16); chk("ref_cf", charge_float, 1);

    // Exact-change purchase: 10 yuan, two item1 + one item2.
    put_coin(2'b10); put_coin(2'b10);
    do_sel(1, 2); do_sel(2, 1);
    buy = 1; tick();
    chk("buy_op", op_start, 1);
    cnt = 0;
    repeat (12) begin
      if (dispense) cnt++;
      tick();
    end
    chk("disp_len", cnt, 8);
    chk("buy_charge", charge_val, 0); chk("buy_cf", charge_float, 0);
    chk("buy_n1", num1, 0); chk("buy_n2", num2, 0); chk("buy_hold", hold_ind, 1);

    // Insufficient credit, then cancel refunds it.
    put_coin(2'b01); put_coin(2'b01);
    do_sel(2, 1);
    buy = 1; tick();
    chk("poor_op", op_start, 1); chk("poor_busy", busy, 0); chk("poor_val", coin_val, 2);
    cancel = 1; tick();
    chk("poor_cflag", cancel_flag, 1); chk("poor_charge", charge_val, 2); chk("poor_val0", coin_val, 0);
    tick();

    // Saturation, then cancel beats buy.
    do_sel(1, 7);
    chk("sat_n1", num1, 5);
    put_coin(2'b11); put_coin(2'b10);
    cancel = 1; buy = 1; tick();
    chk("cb_cflag", cancel_flag, 1); chk("cb_op", op_start, 0); chk("cb_disp", dispense, 0);
    chk("cb_charge", charge_val, 15); chk("cb_n1", num1, 0);
    tick();

    // Reset in the middle of a dispense.
    put_coin(2'b10); do_sel(1, 1);
    buy = 1; tick();
    tick(); tick();
    #2 reset = 0;
    #1;
    model_clear();
    compare_all();
    chk("rst_charge", charge_val, 0); chk("rst_disp", dispense, 0);
    @(negedge clk) reset = 1;
    tick();
    start = 1; tick();

    // Randomized traffic, including occasional power drops and simultaneous pulses.
    for (int i = 0; i < 1500; i++) begin
      power_on   = ($urandom_range(0, 199) != 0);
      start      = ($urandom_range(0, 5) == 0);
      coin_pulse = ($urandom_range(0, 3) == 0);
      coin_sel   = 2'($urandom_range(0, 3));
      sel1       = ($urandom_range(0, 4) == 0);
      sel2       = ($urandom_range(0, 4) == 0);
      buy        = ($urandom_range(0, 9) == 0);
      cancel     = ($urandom_range(0, 24) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
